// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcodes, issue FSM states and issue payload.
// Pure declarations, no timing. No handshake of its own.
// Used by the decode, issue and ALU blocks alike.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001,
    ALU_SGE  = 4'b1010,
    ALU_SGEU = 4'b1011
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_ctrl_e   alu_control;
    logic        illegal;
  } issue_t;

  // Register-register funct3 table; alt selects SUB/SRA.
  function automatic alu_ctrl_e op_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  op_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op_fn = ALU_SLL;
      3'b010:  op_fn = ALU_SLT;
      3'b011:  op_fn = ALU_SLTU;
      3'b100:  op_fn = ALU_XOR;
      3'b101:  op_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op_fn = ALU_OR;
      default: op_fn = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// Decoded-instruction input and ALU-operand output handshake bundle.
// slave = issue block view, master = producer/consumer view.
interface alu_op_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic        illegal;

  modport slave (
    input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, illegal
  );

  modport master (
    output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Maps RV32I opcode/funct fields to ALU operands and operation code.
// Combinational, zero latency. No handshake.
// Unsupported combinations yield illegal=1 with zeroed operands.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output issue_t      dec
);

  always_comb begin
    dec.alu_a       = '0;
    dec.alu_b       = '0;
    dec.alu_control = ALU_ADD;
    dec.illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.alu_a       = rs1_data;
        dec.alu_b       = rs2_data;
        dec.alu_control = op_fn(funct3, funct7_5);
      end
      OPC_OP_IMM: begin
        // Immediate form has no SUB; bit 30 only distinguishes SRAI.
        dec.alu_a       = rs1_data;
        dec.alu_b       = imm;
        dec.alu_control = op_fn(funct3, funct7_5 & (funct3 == 3'b101));
      end
      OPC_BRANCH: begin
        dec.alu_a = rs1_data;
        dec.alu_b = rs2_data;
        case (funct3)
          3'b000, 3'b001: dec.alu_control = ALU_SUB;
          3'b100:         dec.alu_control = ALU_SLT;
          3'b101:         dec.alu_control = ALU_SGE;
          3'b110:         dec.alu_control = ALU_SLTU;
          3'b111:         dec.alu_control = ALU_SGEU;
          default: begin
            dec.alu_a   = '0;
            dec.alu_b   = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        dec.alu_b = imm;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec.alu_a = pc;
        dec.alu_b = imm;
      end
      OPC_JALR, OPC_LOAD, OPC_STORE: begin
        dec.alu_a = rs1_data;
        dec.alu_b = imm;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// Registers decoded ALU operands between decode and execute, in arrival order.
// Latency 1 cycle. SKID_EN=1: 2-entry skid with registered in_ready; SKID_EN=0: 1 entry, in_ready = !out_valid | out_ready.
// flush empties everything next cycle and drops a same-cycle accept.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter bit SKID_EN = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  alu_op_issue_if.slave bus
);

  issue_t dec;
  issue_t out_q, out_d;
  issue_t skid_q, skid_d;
  state_e state_q, state_d;
  logic   rdy_q, rdy_d;
  logic   accept, transfer;

  alu_op_decode u_dec (
    .opcode   (bus.opcode),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .imm      (bus.imm),
    .pc       (bus.pc),
    .dec      (dec)
  );

  // rdy_q is held low in reset so in_ready reads 0 until the first edge afterwards.
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.in_ready  = SKID_EN ? rdy_q : (rdy_q & (~bus.out_valid | bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign transfer      = bus.out_valid & bus.out_ready;

  assign bus.alu_a       = out_q.alu_a;
  assign bus.alu_b       = out_q.alu_b;
  assign bus.alu_control = out_q.alu_control;
  assign bus.illegal     = out_q.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = dec;
        end
      end
      ST_ONE: begin
        if (accept && transfer) begin
          out_d = dec;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = dec;
        end else if (transfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (transfer) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end
    rdy_d = SKID_EN ? (state_d != ST_TWO) : 1'b1;
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed-vector bench for alu_op_issue with the default 2-entry skid configuration.
module tb_alu_op_issue;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_op_issue_if bus ();

  alu_op_issue #(.SKID_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic [31:0] p);
    bus.in_valid = v;
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.funct7_5 = f75;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.imm      = im;
    bus.pc       = p;
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.alu_a !== 32'd0 ||
        bus.alu_b !== 32'd0 || bus.alu_control !== 4'b0000 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b a=%h b=%h c=%b ill=%b, want all zero",
               bus.out_valid, bus.in_ready, bus.alu_a, bus.alu_b, bus.alu_control, bus.illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_sra();
    bus.out_ready = 1'b0;
    drive(1'b1, OPC_OP, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'hdead, 32'hbeef);
    tick();
    idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_control !== 4'b0111 ||
        bus.alu_a !== 32'h8000_0000 || bus.alu_b !== 32'd4 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL op_sra: got v=%b c=%b a=%h b=%h ill=%b, want v=1 c=0111 a=80000000 b=4 ill=0",
               bus.out_valid, bus.alu_control, bus.alu_a, bus.alu_b, bus.illegal);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL op_sra_drain: got v=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_auipc();
    bus.out_ready = 1'b1;
    drive(1'b1, OPC_AUIPC, 3'b010, 1'b1, 32'h1111, 32'h2222, 32'h2000, 32'h1000);
    tick();
    idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_a !== 32'h1000 || bus.alu_b !== 32'h2000 ||
        bus.alu_control !== 4'b0000 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL auipc: got v=%b a=%h b=%h c=%b ill=%b, want v=1 a=1000 b=2000 c=0000 ill=0",
               bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control, bus.illegal);
    end
    tick();
  endtask

  task automatic test_illegal_branch();
    bus.out_ready = 1'b1;
    drive(1'b1, OPC_BRANCH, 3'b011, 1'b0, 32'd5, 32'd6, 32'd7, 32'd8);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.alu_control !== 4'b0000 ||
        bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
      errors++;
      $display("FAIL branch_illegal: got v=%b ill=%b c=%b a=%h b=%h, want v=1 ill=1 c=0000 a=0 b=0",
               bus.out_valid, bus.illegal, bus.alu_control, bus.alu_a, bus.alu_b);
    end
    drive(1'b1, OPC_BRANCH, 3'b101, 1'b0, 32'd5, 32'd6, 32'd7, 32'd8);
    tick();
    checks++;
    if (bus.illegal !== 1'b0 || bus.alu_control !== 4'b1010 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd6) begin
      errors++;
      $display("FAIL branch_bge: got ill=%b c=%b a=%h b=%h, want ill=0 c=1010 a=5 b=6",
               bus.illegal, bus.alu_control, bus.alu_a, bus.alu_b);
    end
    drive(1'b1, 7'b1111111, 3'b000, 1'b0, 32'd5, 32'd6, 32'd7, 32'd8);
    tick();
    idle();
    checks++;
    if (bus.illegal !== 1'b1 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bad_opcode: got ill=%b a=%h b=%h v=%b, want ill=1 a=0 b=0 v=1",
               bus.illegal, bus.alu_a, bus.alu_b, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_opimm_stall();
    bus.out_ready = 1'b0;
    drive(1'b1, OPC_OP_IMM, 3'b000, 1'b1, 32'd10, 32'd99, 32'd3, 32'd0);
    tick();
    drive(1'b0, OPC_OP, 3'b111, 1'b0, 32'hffff, 32'heeee, 32'd1, 32'd2);
    checks++;
    if (bus.alu_control !== 4'b0000 || bus.alu_a !== 32'd10 || bus.alu_b !== 32'd3) begin
      errors++;
      $display("FAIL opimm_add: got c=%b a=%h b=%h, want c=0000 a=a b=3",
               bus.alu_control, bus.alu_a, bus.alu_b);
    end
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_control !== 4'b0000 || bus.alu_a !== 32'd10 || bus.alu_b !== 32'd3) begin
      errors++;
      $display("FAIL stall_stable: got v=%b c=%b a=%h b=%h, want v=1 c=0000 a=a b=3",
               bus.out_valid, bus.alu_control, bus.alu_a, bus.alu_b);
    end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0);
    tick();
    drive(1'b1, OPC_LUI, 3'b000, 1'b0, 32'd9, 32'd9, 32'h5000, 32'd0);
    tick();
    drive(1'b1, OPC_JAL, 3'b000, 1'b0, 32'd9, 32'd9, 32'd8, 32'h40);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.alu_a !== 32'd1 || bus.alu_b !== 32'd2) begin
      errors++;
      $display("FAIL b2b_full: got rdy=%b a=%h b=%h, want rdy=0 a=1 b=2", bus.in_ready, bus.alu_a, bus.alu_b);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.alu_a !== 32'd1) begin
      errors++;
      $display("FAIL b2b_hold: got rdy=%b v=%b a=%h, want rdy=0 v=1 a=1", bus.in_ready, bus.out_valid, bus.alu_a);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'h5000 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got v=%b a=%h b=%h rdy=%b, want v=1 a=0 b=5000 rdy=1",
               bus.out_valid, bus.alu_a, bus.alu_b, bus.in_ready);
    end
    tick();
    idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_a !== 32'h40 || bus.alu_b !== 32'd8) begin
      errors++;
      $display("FAIL b2b_third: got v=%b a=%h b=%h, want v=1 a=40 b=8", bus.out_valid, bus.alu_a, bus.alu_b);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: got v=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_throughput();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OPC_LOAD, 3'b010, 1'b0, 32'h100 + 32'(i), 32'd0, 32'd4, 32'd0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.alu_a !== 32'h100 + 32'(i) || bus.alu_b !== 32'd4) begin
        errors++;
        $display("FAIL throughput_%0d: got v=%b rdy=%b a=%h b=%h, want v=1 rdy=1 a=%h b=4",
                 i, bus.out_valid, bus.in_ready, bus.alu_a, bus.alu_b, 32'h100 + 32'(i));
      end
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, OPC_STORE, 3'b010, 1'b0, 32'd1, 32'd0, 32'd2, 32'd0);
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_two: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_residue_%0d: got v=%b, want 0", i, bus.out_valid);
      end
    end
    drive(1'b1, OPC_OP, 3'b100, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_accept: got v=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, OPC_OP, 3'b110, 1'b0, 32'h77, 32'h88, 32'd0, 32'd0);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.alu_a !== 32'd0 || bus.alu_control !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got v=%b rdy=%b a=%h c=%b, want v=0 rdy=0 a=0 c=0000",
               bus.out_valid, bus.in_ready, bus.alu_a, bus.alu_control);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got rdy=%b v=%b, want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sra();
    test_auipc();
    test_illegal_branch();
    test_opimm_stall();
    test_back_to_back();
    test_throughput();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
